// File: rtl/spram_arb.sv
// Two-requester round-robin arbiter in front of a single-port RAM, with a
// full-memory clear sweep after reset and on request.
module spram_arb #(
  parameter int              DW       = 4,
  parameter int              AW       = 4,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_q,
  output logic          state_dbg
);

  // Handshake: a requester holds req/we/addr/wdata stable until it sees its
  // gnt high; the access is issued to the RAM in that same cycle, and a read
  // returns one cycle later as rvalidX=1 with rdata valid.

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;
  logic          pick0, pick1;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= CLEAR;
      cnt     <= '0;
      last    <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end

  // Next-state logic; clr only matters in RUN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == {AW{1'b1}}) state_nxt = RUN;
      end
      RUN: begin
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
    if (gnt0)      last_nxt = 1'b0;
    else if (gnt1) last_nxt = 1'b1;
  end

  // Output logic: on contention the requester not recorded in last wins
  always_comb begin
    pick0     = req0 & (~req1 | last);
    pick1     = req1 & (~req0 | ~last);
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    busy      = 1'b0;
    mem_wen   = 1'b1;
    mem_addr  = '0;
    mem_data  = '0;
    if (state == CLEAR) begin
      busy     = 1'b1;
      mem_wen  = 1'b0;
      mem_addr = cnt;
      mem_data = INIT_VAL;
    end else if (!clr) begin
      gnt0 = pick0;
      gnt1 = pick1;
      if (pick0) begin
        mem_wen  = ~we0;
        mem_addr = addr0;
        mem_data = wdata0;
      end else if (pick1) begin
        mem_wen  = ~we1;
        mem_addr = addr1;
        mem_data = wdata1;
      end
    end
  end

  assign rdata     = mem_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_spram_arb.sv
// Bench for spram_arb: behavioural write-then-read RAM, a reference memory,
// table-driven cycle vectors and a read-data scoreboard.
module tb_spram_arb;
  localparam int            DW   = 4;
  localparam int            AW   = 4;
  localparam logic [DW-1:0] INIT = '0;

  logic          clk, rstn, clr;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, mem_wen, state_dbg;
  logic [DW-1:0] rdata, mem_data, mem_q;
  logic [AW-1:0] mem_addr;

  spram_arb #(.DW(DW), .AW(AW), .INIT_VAL(INIT)) dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_q(mem_q), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: registered address, write-then-read
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (!mem_wen) ram[mem_addr] <= mem_data;
    mem_q <= (!mem_wen) ? mem_data : ram[mem_addr];
  end

  typedef struct packed {
    logic          clr;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1, bz;
  } vec_t;

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [16];
  logic [AW-1:0] sweep_idx;
  logic          pend0, pend1;
  int            passed, total;
  vec_t          tbl [15];

  function automatic vec_t mk(input logic c,
                              input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic g0, input logic g1, input logic bz);
    vec_t v;
    v.clr = c; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_reset();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 1);
    chk("rst_state", state_dbg, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
  endtask

  // Driver: one clock cycle, inputs applied at negedge, outputs sampled 1ns later
  task automatic run(input vec_t v);
    logic nx0, nx1;
    @(negedge clk);
    clr = v.clr;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    #1;
    chk("gnt0", gnt0, v.g0);
    chk("gnt1", gnt1, v.g1);
    chk("busy", busy, v.bz);
    chk("rvalid0", rvalid0, pend0);
    chk("rvalid1", rvalid1, pend1);
    if (pend0 || pend1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: got empty queue expected one entry (t=%0t)", $time);
      end else begin
        chk("rdata", rdata, exp_q.pop_front());
      end
    end
    nx0 = 1'b0;
    nx1 = 1'b0;
    if (v.bz) begin
      chk("clr_wen", mem_wen, 0);
      chk("clr_addr", mem_addr, sweep_idx);
      chk("clr_data", mem_data, INIT);
      ref_mem[sweep_idx] = INIT;
      sweep_idx++;
    end else if (v.g0) begin
      chk("g0_wen", mem_wen, !v.w0);
      chk("g0_addr", mem_addr, v.a0);
      chk("g0_data", mem_data, v.d0);
      if (v.w0) ref_mem[v.a0] = v.d0;
      else begin exp_q.push_back(ref_mem[v.a0]); nx0 = 1'b1; end
    end else if (v.g1) begin
      chk("g1_wen", mem_wen, !v.w1);
      chk("g1_addr", mem_addr, v.a1);
      chk("g1_data", mem_data, v.d1);
      if (v.w1) ref_mem[v.a1] = v.d1;
      else begin exp_q.push_back(ref_mem[v.a1]); nx1 = 1'b1; end
    end else begin
      chk("idle_wen", mem_wen, 1);
      chk("idle_addr", mem_addr, 0);
      chk("idle_data", mem_data, 0);
      if (v.clr) sweep_idx = '0;
    end
    pend0 = nx0;
    pend1 = nx1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    who;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    passed = 0; total = 0;
    pend0 = 0; pend1 = 0; sweep_idx = '0;
    rstn = 0; clr = 0;
    req0 = 1; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

    // Reset with a pending read held by requester 0
    repeat (3) @(negedge clk);
    #1 check_reset();
    @(posedge clk);
    #2 rstn = 1;
    sweep_idx = '0;

    // Initial sweep: 16 busy cycles, then requester 0 read granted in cycle 17
    for (int i = 0; i < 16; i++) run(mk(0, 1,0,0,0, 0,0,0,0, 0,0,1));
    run(mk(0, 1,0,0,0, 0,0,0,0, 1,0,0));

    // Table of RUN-mode cycles: write/read hazard, contention, back-to-back
    tbl[0]  = mk(0, 1,1,5,4'hA, 0,0,0,0,    1,0,0);
    tbl[1]  = mk(0, 0,0,0,0,    1,0,5,0,    0,1,0);
    tbl[2]  = mk(0, 0,0,0,0,    0,0,0,0,    0,0,0);
    tbl[3]  = mk(0, 1,1,1,4'h3, 1,1,2,4'h4, 1,0,0);
    tbl[4]  = mk(0, 1,1,3,4'h5, 1,1,2,4'h4, 0,1,0);
    tbl[5]  = mk(0, 1,1,3,4'h5, 1,0,1,0,    1,0,0);
    tbl[6]  = mk(0, 1,0,2,0,    1,0,1,0,    0,1,0);
    tbl[7]  = mk(0, 1,0,2,0,    1,0,3,0,    1,0,0);
    tbl[8]  = mk(0, 1,0,5,0,    1,0,3,0,    0,1,0);
    tbl[9]  = mk(0, 1,0,5,0,    0,0,0,0,    1,0,0);
    tbl[10] = mk(0, 1,0,1,0,    0,0,0,0,    1,0,0);
    tbl[11] = mk(0, 1,1,7,4'h9, 1,1,7,4'h2, 0,1,0);
    tbl[12] = mk(0, 1,1,7,4'h9, 0,0,0,0,    1,0,0);
    tbl[13] = mk(0, 0,0,0,0,    1,0,7,0,    0,1,0);
    tbl[14] = mk(0, 0,0,0,0,    0,0,0,0,    0,0,0);
    for (int i = 0; i < 15; i++) run(tbl[i]);

    // Random single-requester traffic
    for (int i = 0; i < 40; i++) begin
      who = 2'($urandom_range(2, 0));
      w   = 1'($urandom_range(1, 0));
      a   = AW'($urandom_range(15, 0));
      d   = DW'($urandom_range(15, 0));
      if (who == 0)      run(mk(0, 1,w,a,d, 0,0,0,0, 1,0,0));
      else if (who == 1) run(mk(0, 0,0,0,0, 1,w,a,d, 0,1,0));
      else               run(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0));
    end
    run(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0));

    // Fill with 0xF, clr, a clr pulse mid-sweep is ignored, then read address 9
    for (int i = 0; i < 16; i++) run(mk(0, 1,1,AW'(i),4'hF, 0,0,0,0, 1,0,0));
    run(mk(1, 0,0,0,0, 1,0,9,0, 0,0,0));
    for (int i = 0; i < 16; i++) run(mk(i == 7, 0,0,0,0, 1,0,9,0, 0,0,1));
    run(mk(0, 0,0,0,0, 1,0,9,0, 0,1,0));
    run(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0));

    // Reset asserted before the edge that would raise rvalid for a granted read
    run(mk(0, 1,1,9,4'hC, 0,0,0,0, 1,0,0));
    run(mk(0, 1,0,9,0,    0,0,0,0, 1,0,0));
    #1 rstn = 0;
    pend0 = 0; pend1 = 0;
    exp_q.delete();
    @(posedge clk);
    #1 chk("rst_drop_rvalid0", rvalid0, 0);
    repeat (2) @(negedge clk);
    #1 check_reset();
    @(posedge clk);
    #2 rstn = 1;
    sweep_idx = '0;
    for (int i = 0; i < 16; i++) run(mk(0, 0,0,0,0, 0,0,0,0, 0,0,1));
    run(mk(0, 0,0,0,0, 1,0,9,0, 0,1,0));
    run(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0));

    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
